wordle_guess_grader: RTL and testbench
======================================

// Module: wordle_guess_grader
// PURPOSE
//  Parametrised Wordle grading engine between the letter-entry state machine and the VGA renderer.
//  Accepts a secret word and up to MAX_GUESSES guesses, then scores each letter as absent, present or correct.
//  Repeated letters are counted correctly. Each scored row goes into a history memory, and the VGA side reads it per tile.
//  Tracks win and lose status for the game.
// PARAMETERS
//  WORD_LEN     5  letters per word
//  CHAR_W       8  bits per letter (ASCII); letter 0 = word MSBs (leftmost)
//  MAX_GUESSES  6  rows / guesses per game
// PORTS
//  board_clk     in   1                   system clock
//  reset         in   1                   async, active-high
//  secret_load   in   1                   pulse: latch secret_word, start new game
//  secret_word   in   WORD_LEN*CHAR_W     secret word
//  guess_valid   in   1                   guess offered
//  guess_ready   out  1                   grader can accept a guess
//  guess_word    in   WORD_LEN*CHAR_W     guess word
//  result_valid  out  1                   1-cycle pulse: row scored
//  result_score  out  2*WORD_LEN          score of letter i on bits [2i+1:2i]
//  result_row    out  clog2(MAX_GUESSES)  row just written
//  win           out  1                   sticky: last guess all-correct
//  lose          out  1                   sticky: MAX_GUESSES used, no win
//  rd_row        in   clog2(MAX_GUESSES)  history read row
//  rd_col        in   clog2(WORD_LEN)     history read column
//  rd_score      out  2                   score at rd_row/rd_col, 1-cycle registered latency
// BEHAVIOUR
//  Reset: reset is asynchronous and active-high; the clock is board_clk.
//   - Asserting reset clears every output, the history, guess_count and game_active to 0.
//   - Asserting reset mid-scoring aborts the row: no result_valid, nothing written.
//  Score encoding: 00 blank, 01 absent, 10 present, 11 correct.
//  States: IDLE, GREEN, YELLOW, WRITE, OVER.
//  guess_ready = (state==IDLE) & game_active.
//  Handshake: a guess is accepted on the edge where guess_valid & guess_ready.
//   - guess_word and secret are snapshotted at that edge.
//   - guess_valid while not ready is ignored; nothing is queued.
//  GREEN: one letter per cycle, i = 0..WORD_LEN-1.
//   - Position i is correct when guess[i]==secret[i].
//   - A correct position marks secret[i] as consumed.
//  YELLOW: one letter per cycle, skipping no cycles.
//   - A non-correct letter i takes the lowest unconsumed j with secret[j]==guess[i], marks j consumed, and scores present.
//   - If no such j exists, the letter is absent.
//  WRITE: stores the row at guess_count and increments guess_count.
//   - If all letters are correct: win=1, state OVER.
//   - Otherwise, if guess_count reaches MAX_GUESSES: lose=1, state OVER.
//   - Otherwise: IDLE.
//  Latency: result_valid pulses exactly 2*WORD_LEN+2 edges after the accept edge.
//   - result_score and result_row are held stable until the next result.
//  secret_load is honoured only in IDLE or OVER; it is ignored while scoring.
//   - On load: history cleared to 00, guess_count=0, win=lose=0, game_active=1.
//  A write and a read of the same cell in the same cycle: rd_score returns the old value.
//  Out-of-range rd_row/rd_col: rd_score returns 00.
// CONFIGURATION
//  GRADER_DUP_AWARE_EN defined: duplicate-aware YELLOW pass as above.
//  GRADER_DUP_AWARE_EN undefined: naive scoring, no consumption tracking.
//   - A non-correct letter is present if it equals any secret letter.
//   - Otherwise it is absent.
//   - Latency is unchanged.
// STRUCTURE
//  wordle_pkg: score encodings (SCORE_BLANK/ABSENT/PRESENT/CORRECT), state enum, state width.
//  Sub-module wordle_letter_matcher (combinational): inputs letter, secret, consumed mask.
//   - Outputs hit and one-hot index of the lowest unconsumed match.
//  The top holds FSM, counters, consumed mask and history registers.
// TESTING
//  1 secret "CRANE", guess "CRANE" -> score 11,11,11,11,11; win=1; guess_ready stays 0 until next secret_load.
//  2 secret "APPLE", guess "PAPAL" -> with GRADER_DUP_AWARE_EN: 10,10,11,01,10; without: 10,10,11,10,10.
//  3 six guesses "ZZZZZ" vs "CRANE" -> rows 0..5 all 01; lose=1 after 6th result_valid; 7th guess not accepted.
//  4 guess_valid held during scoring, second word changed mid-row -> only first word scored; second accepted once ready.
//  5 reset asserted 3 cycles after accept -> no result_valid; rd_score 00 for all cells; win=lose=0.
//  6 secret_load after win -> every rd_score 00, guess_count 0, result_row of next result = 0.

Source files
------------

// File: rtl/wordle_pkg.sv
// Shared types for the Wordle guess grader: per-letter score encodings,
// the grading state machine encoding and its width.
package wordle_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [1:0] score_t;

  localparam score_t SCORE_BLANK   = 2'b00;
  localparam score_t SCORE_ABSENT  = 2'b01;
  localparam score_t SCORE_PRESENT = 2'b10;
  localparam score_t SCORE_CORRECT = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_WRITE  = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

endpackage

// File: rtl/wordle_guess_grader_if.sv
// Bus between the letter-entry FSM / VGA renderer (master) and the grader
// (slave).
//   secret_load/secret_word         : start a new game with a secret word
//   guess_valid/guess_ready/word    : guess handshake
//   result_valid/score/row, win/lose: scored-row report and game status
//   rd_row/rd_col -> rd_score       : per-tile history read, 1-cycle latency
interface wordle_guess_grader_if #(
  parameter int unsigned WORD_LEN    = 5,
  parameter int unsigned CHAR_W      = 8,
  parameter int unsigned MAX_GUESSES = 6
);
  localparam int unsigned WORD_W  = WORD_LEN * CHAR_W;
  localparam int unsigned SCORE_W = 2 * WORD_LEN;
  localparam int unsigned ROW_W   = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam int unsigned COL_W   = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  logic               secret_load;
  logic [WORD_W-1:0]  secret_word;
  logic               guess_valid;
  logic               guess_ready;
  logic [WORD_W-1:0]  guess_word;
  logic               result_valid;
  logic [SCORE_W-1:0] result_score;
  logic [ROW_W-1:0]   result_row;
  logic               win;
  logic               lose;
  logic [ROW_W-1:0]   rd_row;
  logic [COL_W-1:0]   rd_col;
  logic [1:0]         rd_score;

  modport master (
    output secret_load, secret_word, guess_valid, guess_word, rd_row, rd_col,
    input  guess_ready, result_valid, result_score, result_row, win, lose, rd_score
  );

  modport slave (
    input  secret_load, secret_word, guess_valid, guess_word, rd_row, rd_col,
    output guess_ready, result_valid, result_score, result_row, win, lose, rd_score
  );

endinterface

// File: rtl/wordle_letter_matcher.sv
// Combinational search of one guess letter against the secret word.
//   letter     : guess letter under test
//   secret     : secret word, letter 0 in the MSBs
//   consumed   : secret positions already claimed (bit j = letter j)
//   hit_c      : some unconsumed secret letter equals `letter`
//   idx_oh_c   : one-hot of the lowest such position (bit j = letter j)
module wordle_letter_matcher #(
  parameter int unsigned WORD_LEN = 5,
  parameter int unsigned CHAR_W   = 8
) (
  input  logic [CHAR_W-1:0]          letter,
  input  logic [WORD_LEN*CHAR_W-1:0] secret,
  input  logic [WORD_LEN-1:0]        consumed,
  output logic                       hit_c,
  output logic [WORD_LEN-1:0]        idx_oh_c
);

  logic [WORD_LEN-1:0] eq;

  // Per-position equality, masked by positions already used.
  for (genvar j = 0; j < WORD_LEN; j++) begin : g_eq
    assign eq[j] = !consumed[j] &&
                   (secret[(WORD_LEN-1-j)*CHAR_W +: CHAR_W] == letter);
  end

  // Isolate the lowest set bit: lowest letter index wins.
  assign idx_oh_c = eq & (~eq + WORD_LEN'(1));
  assign hit_c    = |eq;

endmodule

// File: rtl/wordle_guess_grader.sv
// Wordle grading engine: latches a secret, accepts up to MAX_GUESSES guesses,
// scores each one letter-per-cycle (GREEN pass, then YELLOW pass), stores the
// row in a history memory and reports win/lose.
// Ports:
//   board_clk : clock
//   reset     : asynchronous, active-high
//   bus       : wordle_guess_grader_if.slave (secret, guess, result, history read)
// Build option:
//   GRADER_DUP_AWARE_EN defined   -> repeated letters consume secret positions
//   GRADER_DUP_AWARE_EN undefined -> naive "letter appears anywhere" scoring
module wordle_guess_grader
  import wordle_pkg::*;
#(
  parameter int unsigned WORD_LEN    = 5,
  parameter int unsigned CHAR_W      = 8,
  parameter int unsigned MAX_GUESSES = 6
) (
  input logic              board_clk,
  input logic              reset,
  wordle_guess_grader_if.slave bus
);

  localparam int unsigned WORD_W  = WORD_LEN * CHAR_W;
  localparam int unsigned SCORE_W = 2 * WORD_LEN;
  localparam int unsigned ROW_W   = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam int unsigned COL_W   = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam int unsigned CNT_W   = $clog2(MAX_GUESSES + 1);

  state_e                            state_q, state_d;
  logic [WORD_W-1:0]                 secret_q, secret_d;
  logic [WORD_W-1:0]                 guess_q, guess_d;
  logic [COL_W-1:0]                  idx_q, idx_d;
  logic [WORD_LEN-1:0]               consumed_q, consumed_d;
  logic [SCORE_W-1:0]                score_q, score_d;
  logic [CNT_W-1:0]                  guess_count_q, guess_count_d;
  logic                              game_active_q, game_active_d;
  logic                              guess_ready_q, guess_ready_d;
  logic                              result_valid_q, result_valid_d;
  logic [SCORE_W-1:0]                result_score_q, result_score_d;
  logic [ROW_W-1:0]                  result_row_q, result_row_d;
  logic                              pend_q, pend_d;
  logic [ROW_W-1:0]                  pend_row_q, pend_row_d;
  logic                              win_q, win_d;
  logic                              lose_q, lose_d;
  logic [MAX_GUESSES-1:0][SCORE_W-1:0] hist_q, hist_d;
  logic [1:0]                        rd_score_q, rd_score_d;

  logic [CHAR_W-1:0]   guess_let  [WORD_LEN];
  logic [CHAR_W-1:0]   secret_let [WORD_LEN];
  logic [WORD_LEN-1:0] match_mask;
  logic                match_hit;
  logic [WORD_LEN-1:0] match_oh;
  logic                accept;
  logic                load;
  logic                rd_in_range;

  // Letter views of the snapshotted words, letter 0 = MSBs.
  for (genvar i = 0; i < WORD_LEN; i++) begin : g_let
    assign guess_let[i]  = guess_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W];
    assign secret_let[i] = secret_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W];
  end

  // Naive scoring ignores consumption; bookkeeping still runs but is unseen.
`ifdef GRADER_DUP_AWARE_EN
  assign match_mask = consumed_q;
`else
  assign match_mask = '0;
`endif

  wordle_letter_matcher #(
    .WORD_LEN (WORD_LEN),
    .CHAR_W   (CHAR_W)
  ) u_matcher (
    .letter   (guess_let[idx_q]),
    .secret   (secret_q),
    .consumed (match_mask),
    .hit_c    (match_hit),
    .idx_oh_c (match_oh)
  );

  assign accept = bus.guess_valid && guess_ready_q;
  assign load   = bus.secret_load && ((state_q == ST_IDLE) || (state_q == ST_OVER));
  assign rd_in_range = (32'(bus.rd_row) < MAX_GUESSES) && (32'(bus.rd_col) < WORD_LEN);

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    secret_d       = secret_q;
    guess_d        = guess_q;
    idx_d          = idx_q;
    consumed_d     = consumed_q;
    score_d        = score_q;
    guess_count_d  = guess_count_q;
    game_active_d  = game_active_q;
    win_d          = win_q;
    lose_d         = lose_q;
    hist_d         = hist_q;
    pend_d         = 1'b0;
    pend_row_d     = pend_row_q;
    result_valid_d = 1'b0;
    result_score_d = result_score_q;
    result_row_d   = result_row_q;

    // Row committed last cycle is reported now; score_q is still that row.
    if (pend_q) begin
      result_valid_d = 1'b1;
      result_score_d = score_q;
      result_row_d   = pend_row_q;
    end

    if (load) begin
      secret_d      = bus.secret_word;
      hist_d        = '0;
      guess_count_d = '0;
      win_d         = 1'b0;
      lose_d        = 1'b0;
      game_active_d = 1'b1;
      state_d       = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            guess_d    = bus.guess_word;
            idx_d      = '0;
            consumed_d = '0;
            score_d    = '0;
            state_d    = ST_GREEN;
          end
        end

        ST_GREEN: begin
          if (guess_let[idx_q] == secret_let[idx_q]) begin
            score_d[{idx_q, 1'b0} +: 2] = SCORE_CORRECT;
            consumed_d[idx_q]           = 1'b1;
          end
          if (idx_q == COL_W'(WORD_LEN - 1)) begin
            idx_d   = '0;
            state_d = ST_YELLOW;
          end else begin
            idx_d = idx_q + COL_W'(1);
          end
        end

        ST_YELLOW: begin
          // Correct letters keep their score; the cycle is still spent.
          if (score_q[{idx_q, 1'b0} +: 2] != SCORE_CORRECT) begin
            if (match_hit) begin
              score_d[{idx_q, 1'b0} +: 2] = SCORE_PRESENT;
              consumed_d                  = consumed_q | match_oh;
            end else begin
              score_d[{idx_q, 1'b0} +: 2] = SCORE_ABSENT;
            end
          end
          if (idx_q == COL_W'(WORD_LEN - 1)) begin
            idx_d   = '0;
            state_d = ST_WRITE;
          end else begin
            idx_d = idx_q + COL_W'(1);
          end
        end

        ST_WRITE: begin
          hist_d[ROW_W'(guess_count_q)] = score_q;
          guess_count_d = guess_count_q + CNT_W'(1);
          pend_d        = 1'b1;
          pend_row_d    = ROW_W'(guess_count_q);
          if (score_q == {WORD_LEN{SCORE_CORRECT}}) begin
            win_d   = 1'b1;
            state_d = ST_OVER;
          end else if (guess_count_d == CNT_W'(MAX_GUESSES)) begin
            lose_d  = 1'b1;
            state_d = ST_OVER;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_OVER: begin
          state_d = ST_OVER;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    guess_ready_d = (state_d == ST_IDLE) && game_active_d;

    // History read sees the pre-write contents (hist_q), out-of-range reads 00.
    rd_score_d = SCORE_BLANK;
    if (rd_in_range) begin
      rd_score_d = hist_q[bus.rd_row][{bus.rd_col, 1'b0} +: 2];
    end
  end

  // State and output registers.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      secret_q       <= '0;
      guess_q        <= '0;
      idx_q          <= '0;
      consumed_q     <= '0;
      score_q        <= '0;
      guess_count_q  <= '0;
      game_active_q  <= 1'b0;
      guess_ready_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_score_q <= '0;
      result_row_q   <= '0;
      pend_q         <= 1'b0;
      pend_row_q     <= '0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      hist_q         <= '0;
      rd_score_q     <= '0;
    end else begin
      state_q        <= state_d;
      secret_q       <= secret_d;
      guess_q        <= guess_d;
      idx_q          <= idx_d;
      consumed_q     <= consumed_d;
      score_q        <= score_d;
      guess_count_q  <= guess_count_d;
      game_active_q  <= game_active_d;
      guess_ready_q  <= guess_ready_d;
      result_valid_q <= result_valid_d;
      result_score_q <= result_score_d;
      result_row_q   <= result_row_d;
      pend_q         <= pend_d;
      pend_row_q     <= pend_row_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      hist_q         <= hist_d;
      rd_score_q     <= rd_score_d;
    end
  end

  assign bus.guess_ready  = guess_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_score = result_score_q;
  assign bus.result_row   = result_row_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;
  assign bus.rd_score     = rd_score_q;

endmodule

// File: tb/tb_wordle_guess_grader.sv
// Self-checking bench for wordle_guess_grader (5 letters, 8-bit chars, 6 rows).
// Expected rows are pushed to a scoreboard on each accepted guess and checked
// by a monitor when result_valid pulses.
module tb_wordle_guess_grader;

  localparam int unsigned WL = 5;
  localparam int unsigned CW = 8;
  localparam int unsigned MG = 6;

`ifdef GRADER_DUP_AWARE_EN
  localparam logic [9:0] APPLE_PAPAL = 10'b10_01_11_10_10;
`else
  localparam logic [9:0] APPLE_PAPAL = 10'b10_10_11_10_10;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wordle_guess_grader_if #(.WORD_LEN(WL), .CHAR_W(CW), .MAX_GUESSES(MG)) bus ();

  wordle_guess_grader #(.WORD_LEN(WL), .CHAR_W(CW), .MAX_GUESSES(MG)) dut (
    .board_clk (clk),
    .reset     (rst),
    .bus       (bus)
  );

  typedef struct {
    logic [9:0] score;
    logic [2:0] row;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  int   exp_row = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard check on every result pulse (score, row and latency).
  always @(negedge clk) begin
    if (!rst && bus.result_valid === 1'b1) begin
      n_run++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: result_valid=1 score=%h row=%0d, required no result",
                 bus.result_score, bus.result_row);
      end else begin
        mon_e = sb.pop_front();
        if (bus.result_score !== mon_e.score || bus.result_row !== mon_e.row || cyc !== mon_e.due) begin
          n_fail++;
          $display("FAIL result: score=%b row=%0d cycle=%0d, required score=%b row=%0d cycle=%0d",
                   bus.result_score, bus.result_row, cyc, mon_e.score, mon_e.row, mon_e.due);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  // Reference scorer: letter 0 in MSBs, score of letter i at bits [2i+1:2i].
  function automatic logic [9:0] ref_score(input logic [39:0] s, input logic [39:0] g);
    logic [7:0] sl [5];
    logic [7:0] gl [5];
    logic       used [5];
    logic       corr [5];
    logic       found;
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      sl[i] = 8'(s >> (8 * (4 - i)));
      gl[i] = 8'(g >> (8 * (4 - i)));
      used[i] = 1'b0;
      corr[i] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      if (gl[i] == sl[i]) begin
        corr[i] = 1'b1;
        used[i] = 1'b1;
        r = r | (10'(3) << (2 * i));
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (!corr[i]) begin
        found = 1'b0;
        for (int j = 0; j < 5; j++) begin
`ifdef GRADER_DUP_AWARE_EN
          if (!found && !used[j] && sl[j] == gl[i]) begin
            found   = 1'b1;
            used[j] = 1'b1;
          end
`else
          if (sl[j] == gl[i]) found = 1'b1;
`endif
        end
        r = r | ((found ? 10'(2) : 10'(1)) << (2 * i));
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_secret(input logic [39:0] w);
    bus.secret_word = w;
    bus.secret_load = 1'b1;
    tick();
    bus.secret_load = 1'b0;
    exp_row = 0;
  endtask

  task automatic send_guess(input logic [39:0] w, input logic [9:0] exp);
    int n;
    n = 0;
    while (bus.guess_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus.guess_ready !== 1'b1) begin
      n_run++;
      n_fail++;
      $display("FAIL guess_ready_timeout: guess_ready=%b, required 1", bus.guess_ready);
    end else begin
      bus.guess_word  = w;
      bus.guess_valid = 1'b1;
      tick();
      sb.push_back('{exp, 3'(exp_row), cyc + 12});
      exp_row++;
      bus.guess_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL result_timeout: %0d rows pending, required 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic read_cell(input int r, input int c, output logic [1:0] v);
    bus.rd_row = 3'(r);
    bus.rd_col = 3'(c);
    tick();
    v = bus.rd_score;
  endtask

  task automatic check_history(input string name, input logic [1:0] in_val);
    logic [1:0] v;
    logic [1:0] e;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        read_cell(r, c, v);
        e = (r < 6 && c < 5) ? in_val : 2'b00;
        n_run++;
        if (v !== e) begin
          n_fail++;
          $display("FAIL %s rd[%0d][%0d]: rd_score=%b, required %b", name, r, c, v, e);
        end
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_run++;
    if (bus.guess_ready !== 1'b0 || bus.result_valid !== 1'b0 || bus.result_score !== 10'd0 ||
        bus.result_row !== 3'd0 || bus.win !== 1'b0 || bus.lose !== 1'b0 || bus.rd_score !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rv=%b score=%h row=%0d win=%b lose=%b rd=%b, required all 0",
               bus.guess_ready, bus.result_valid, bus.result_score, bus.result_row,
               bus.win, bus.lose, bus.rd_score);
    end
    rst = 1'b0;
    tick();
    check_bit("ready_before_load", bus.guess_ready, 1'b0);
  endtask

  task automatic test_win();
    logic seen_ready;
    load_secret("CRANE");
    check_bit("ready_after_load", bus.guess_ready, 1'b1);
    send_guess("CRANE", 10'h3FF);
    drain();
    check_bit("win_after_correct", bus.win, 1'b1);
    check_bit("lose_after_win", bus.lose, 1'b0);
    seen_ready = 1'b0;
    bus.guess_word  = "CRANE";
    bus.guess_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (bus.guess_ready !== 1'b0) seen_ready = 1'b1;
      tick();
    end
    bus.guess_valid = 1'b0;
    check_bit("ready_low_after_win", seen_ready, 1'b0);
  endtask

  task automatic test_dup();
    load_secret("APPLE");
    send_guess("PAPAL", APPLE_PAPAL);
    drain();
    send_guess("PPPPP", ref_score("APPLE", "PPPPP"));
    drain();
    send_guess("LEAPP", ref_score("APPLE", "LEAPP"));
    drain();
    check_bit("win_after_dup", bus.win, 1'b0);
  endtask

  task automatic test_lose();
    logic seen_ready;
    load_secret("CRANE");
    for (int k = 0; k < 6; k++) begin
      send_guess("ZZZZZ", 10'h155);
      drain();
      if (k < 5) check_bit("lose_early", bus.lose, 1'b0);
    end
    check_bit("lose_after_6", bus.lose, 1'b1);
    check_bit("win_after_6", bus.win, 1'b0);
    check_history("lose_history", 2'b01);
    seen_ready = 1'b0;
    bus.guess_word  = "CRANE";
    bus.guess_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (bus.guess_ready !== 1'b0) seen_ready = 1'b1;
      tick();
    end
    bus.guess_valid = 1'b0;
    check_bit("seventh_not_ready", seen_ready, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    load_secret("CRANE");
    bus.guess_word  = "CRONE";
    bus.guess_valid = 1'b1;
    tick();
    sb.push_back('{ref_score("CRANE", "CRONE"), 3'(exp_row), cyc + 12});
    exp_row++;
    bus.guess_word = "TRACE";
    n = 0;
    while (bus.guess_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_bit("ready_again", bus.guess_ready, 1'b1);
    tick();
    sb.push_back('{ref_score("CRANE", "TRACE"), 3'(exp_row), cyc + 12});
    exp_row++;
    bus.guess_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    load_secret("CRANE");
    send_guess("CRANE", 10'h3FF);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    sb.delete();
    exp_row = 0;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check_bit("win_after_abort", bus.win, 1'b0);
    check_bit("lose_after_abort", bus.lose, 1'b0);
    check_bit("ready_after_abort", bus.guess_ready, 1'b0);
    check_history("abort_history", 2'b00);
  endtask

  task automatic test_reload();
    load_secret("CRANE");
    send_guess("CRANE", 10'h3FF);
    drain();
    check_bit("win_before_reload", bus.win, 1'b1);
    load_secret("SLATE");
    check_bit("win_cleared", bus.win, 1'b0);
    check_bit("ready_after_reload", bus.guess_ready, 1'b1);
    check_history("reload_history", 2'b00);
    send_guess("STALE", ref_score("SLATE", "STALE"));
    drain();
  endtask

  task automatic test_random();
    logic [39:0] s;
    logic [39:0] g;
    logic [9:0]  e;
    logic        won;
    for (int game = 0; game < 4; game++) begin
      s = '0;
      for (int i = 0; i < 5; i++) s = (s << 8) | 40'(8'h41 + 8'($urandom_range(0, 2)));
      load_secret(s);
      won = 1'b0;
      for (int k = 0; k < 6 && !won; k++) begin
        g = '0;
        for (int i = 0; i < 5; i++) g = (g << 8) | 40'(8'h41 + 8'($urandom_range(0, 2)));
        e = ref_score(s, g);
        send_guess(g, e);
        drain();
        if (e == 10'h3FF) won = 1'b1;
      end
      check_bit("random_win", bus.win, won);
      check_bit("random_lose", bus.lose, !won);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.secret_load = 1'b0;
    bus.secret_word = '0;
    bus.guess_valid = 1'b0;
    bus.guess_word  = '0;
    bus.rd_row      = '0;
    bus.rd_col      = '0;

    test_reset();
    test_win();
    test_dup();
    test_lose();
    test_back_to_back();
    test_reset_mid();
    test_reload();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
